// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the MEM-stage bus controller: FSM states,
// UART register map, status bit layout and the address decode helper.
package mem_bus_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, RD1, RD2, WR1, WR2, WR3, URD1, URD2, UWR1, UWR2, UWR3, DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_SRAM, REG_UDATA, REG_USTAT
    } region_t;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    localparam int STAT_TX_FREE  = 0;
    localparam int STAT_RX_READY = 1;

    localparam logic STROBE_IDLE = 1'b1;

    function automatic region_t decode_addr(input logic [15:0] a,
                                            input logic [15:0] data_a,
                                            input logic [15:0] stat_a);
        if (a == data_a)      return REG_UDATA;
        else if (a == stat_a) return REG_USTAT;
        else                  return REG_SRAM;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle RAM1 / UART bus sequencer behind the MEM stage. Strobes are
// registered from the next state so they are glitch-free and reset-forced.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = mem_bus_ctrl_pkg::UART_DATA_ADDR,
    parameter logic [15:0] UART_STAT_ADDR = mem_bus_ctrl_pkg::UART_STAT_ADDR,
    parameter int          RAM_ADDR_W     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_en_n,
    input  logic                  req_write,
    input  logic [15:0]           addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic                  busy,
    output logic                  ack,
    output logic [RAM_ADDR_W-1:0] ram1_addr,
    output logic                  ram1_en_n,
    output logic                  ram1_oe_n,
    output logic                  ram1_we_n,
    output logic [15:0]           bus_dq_o,
    output logic                  bus_dq_oe,
    input  logic [15:0]           bus_dq_i,
    output logic                  uart_rdn,
    output logic                  uart_wrn,
    input  logic                  uart_data_ready,
    input  logic                  uart_tbre,
    input  logic                  uart_tsre
);

    state_t      r_state;
    state_t      w_next;
    region_t     w_region;
    logic [15:0] r_wdata;
    logic [15:0] w_wdata;
    logic [15:0] w_status;
    logic        w_accept;
    logic        w_drive;

    assign w_region = decode_addr(addr, UART_DATA_ADDR, UART_STAT_ADDR);
    assign w_accept = (r_state == IDLE) && !req_en_n;
    assign busy     = ((r_state != IDLE) && (r_state != DONE)) || w_accept;
    // On the accepting edge the latch is not yet loaded, so forward the input.
    assign w_wdata  = (r_state == IDLE) ? wdata : r_wdata;
    assign w_drive  = w_next inside {WR1, WR2, WR3, UWR1, UWR2, UWR3};

    always_comb begin
        w_status = '0;
        w_status[STAT_RX_READY] = uart_data_ready;
        w_status[STAT_TX_FREE]  = uart_tbre & uart_tsre;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!req_en_n) begin
                    unique case (w_region)
                        REG_UDATA: w_next = req_write ? UWR1 : URD1;
                        REG_USTAT: w_next = DONE;
                        default:   w_next = req_write ? WR1 : RD1;
                    endcase
                end
            end
            RD1:     w_next = RD2;
            RD2:     w_next = DONE;
            WR1:     w_next = WR2;
            WR2:     w_next = WR3;
            WR3:     w_next = DONE;
            URD1:    w_next = URD2;
            URD2:    w_next = DONE;
            UWR1:    w_next = UWR2;
            UWR2:    w_next = UWR3;
            UWR3:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wdata   <= '0;
            rdata     <= '0;
            ack       <= 1'b0;
            ram1_addr <= '0;
            ram1_en_n <= STROBE_IDLE;
            ram1_oe_n <= STROBE_IDLE;
            ram1_we_n <= STROBE_IDLE;
            uart_rdn  <= STROBE_IDLE;
            uart_wrn  <= STROBE_IDLE;
            bus_dq_o  <= '0;
            bus_dq_oe <= 1'b0;
        end else begin
            r_state   <= w_next;
            ack       <= (w_next == DONE);
            ram1_en_n <= !(w_next inside {RD1, RD2, WR1, WR2, WR3});
            ram1_oe_n <= !(w_next inside {RD1, RD2});
            ram1_we_n <= !(w_next == WR2);
            uart_rdn  <= !(w_next inside {URD1, URD2});
            uart_wrn  <= !(w_next == UWR2);
            bus_dq_oe <= w_drive;
            bus_dq_o  <= w_drive ? w_wdata : '0;
            if (w_accept) begin
                r_wdata <= wdata;
                if (w_region == REG_SRAM)
                    ram1_addr <= RAM_ADDR_W'(addr);
                if (w_region == REG_USTAT && !req_write)
                    rdata <= w_status;
            end
            if (r_state == RD2)
                rdata <= bus_dq_i;
            if (r_state == URD2)
                rdata <= {8'h00, bus_dq_i[7:0]};
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: expected load results and ack latency
// are queued at issue and retired by the ack monitor.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en_n, req_write;
    logic [15:0] addr, wdata, rdata, bus_dq_o, bus_dq_i;
    logic        busy, ack, ram1_en_n, ram1_oe_n, ram1_we_n, bus_dq_oe;
    logic [17:0] ram1_addr;
    logic        uart_rdn, uart_wrn, uart_data_ready, uart_tbre, uart_tsre;

    mem_bus_ctrl dut (
        .clk(clk), .rst(rst), .req_en_n(req_en_n), .req_write(req_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .ack(ack),
        .ram1_addr(ram1_addr), .ram1_en_n(ram1_en_n), .ram1_oe_n(ram1_oe_n),
        .ram1_we_n(ram1_we_n), .bus_dq_o(bus_dq_o), .bus_dq_oe(bus_dq_oe),
        .bus_dq_i(bus_dq_i), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] rd;
        int          acc;
        int          lat;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, cur_acc = 0, wpos = 0, n_inv = 0;
    int          n_en, n_oe, n_dqoe, n_wr, n_rdn;
    logic [15:0] dq_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle strobe accounting, bus invariants and scoreboard retirement.
    always @(negedge clk) begin
        cyc++;
        if (!ram1_en_n) n_en++;
        if (!ram1_oe_n) n_oe++;
        if (!uart_rdn)  n_rdn++;
        if (bus_dq_oe) begin
            n_dqoe++;
            dq_seen = bus_dq_o;
        end
        if (!ram1_we_n || !uart_wrn) begin
            n_wr++;
            wpos = cyc - cur_acc;
        end
        if ((bus_dq_oe && (!ram1_oe_n || !uart_rdn)) ||
            (!ram1_en_n && (!uart_rdn || !uart_wrn)) ||
            (!ram1_we_n && !uart_wrn))
            n_inv++;
        if (ack && !rst) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_lat"}, cyc - mon_e.acc, mon_e.lat);
                chk({mon_e.tag, "_rdata"}, rdata, mon_e.rd);
                chk({mon_e.tag, "_busy_done"}, busy, 0);
            end
        end
    end

    task automatic clear_cnt();
        n_en = 0; n_oe = 0; n_dqoe = 0; n_wr = 0; n_rdn = 0;
    endtask

    task automatic wait_ack(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = ack;
        end
        chk({tag, "_ack_seen"}, got, 1);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
    task automatic access(input string tag, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] dq,
                          input logic [15:0] ex, input int lat, input int e_en,
                          input int e_oe, input int e_dqoe, input int e_wr, input int e_rdn);
        clear_cnt();
        req_write = wr; addr = a; wdata = wd; bus_dq_i = dq; req_en_n = 1'b0;
        #1 chk({tag, "_busy_acc"}, busy, 1);
        cur_acc = cyc + 1;
        sb.push_back('{tag, ex, cyc + 1, lat});
        @(posedge clk); #1;
        // Scramble request inputs; the DUT must work from latched values.
        req_en_n = 1'b1; addr = ~a; wdata = ~wd; req_write = !wr;
        if (e_en > 0) chk({tag, "_ram_addr"}, ram1_addr, {2'b00, a});
        wait_ack(tag);
        @(posedge clk); #1;
        chk({tag, "_n_en"}, n_en, e_en);
        chk({tag, "_n_oe"}, n_oe, e_oe);
        chk({tag, "_n_dqoe"}, n_dqoe, e_dqoe);
        chk({tag, "_n_wr"}, n_wr, e_wr);
        chk({tag, "_n_rdn"}, n_rdn, e_rdn);
        if (e_dqoe > 0) chk({tag, "_dq_o"}, dq_seen, wd);
        if (e_wr > 0)   chk({tag, "_wr_pos"}, wpos, 2);
    endtask

    initial begin
        logic [15:0] ra, rd;
        rst = 1'b1; req_en_n = 1'b1; req_write = 1'b0; addr = '0; wdata = '0;
        bus_dq_i = '0; uart_data_ready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dq_oe", bus_dq_oe, 0);
        chk("rst_dq_o", bus_dq_o, 0);
        chk("rst_ram_addr", ram1_addr, 0);
        chk("rst_strobes", {ram1_en_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn}, 5'h1f);
        rst = 1'b0;
        @(posedge clk); #1;

        access("rd",      0, 16'h1234, 16'h0000, 16'hABCD, 16'hABCD, 3, 2, 2, 0, 0, 0);
        access("wr",      1, 16'hBF10, 16'h5A5A, 16'h0000, 16'hABCD, 4, 3, 0, 3, 1, 0);
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
        access("st_rd2",  0, 16'hBF01, 16'h0000, 16'hFFFF, 16'h0002, 1, 0, 0, 0, 0, 0);
        uart_data_ready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
        access("st_rd1",  0, 16'hBF01, 16'h0000, 16'hFFFF, 16'h0001, 1, 0, 0, 0, 0, 0);
        access("st_wr",   1, 16'hBF01, 16'hFFFF, 16'h0000, 16'h0001, 1, 0, 0, 0, 0, 0);
        access("u_wr",    1, 16'hBF00, 16'h0041, 16'h0000, 16'h0001, 4, 0, 0, 3, 1, 0);
        access("u_rd",    0, 16'hBF00, 16'h0000, 16'hFF37, 16'h0037, 3, 0, 0, 0, 0, 2);
        access("rd_beff", 0, 16'hBEFF, 16'h0000, 16'h1357, 16'h1357, 3, 2, 2, 0, 0, 0);
        access("rd_bf02", 0, 16'hBF02, 16'h0000, 16'h2468, 16'h2468, 3, 2, 2, 0, 0, 0);
        access("rd_ffff", 0, 16'hFFFF, 16'h0000, 16'h8001, 16'h8001, 3, 2, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom_range(0, 16'hBEFF));
            rd = 16'($urandom);
            access("rd_rand", 0, ra, 16'h0000, rd, rd, 3, 2, 2, 0, 0, 0);
        end

        // Request held low across DONE: a second read is accepted only in IDLE.
        clear_cnt();
        req_write = 1'b0; addr = 16'h0100; bus_dq_i = 16'h1111; req_en_n = 1'b0;
        sb.push_back('{"held1", 16'h1111, cyc + 1, 3});
        sb.push_back('{"held2", 16'h1111, cyc + 5, 3});
        wait_ack("held1");
        chk("held_busy_in_done", busy, 0);
        @(negedge clk);
        chk("held_idle_busy", busy, 1);
        chk("held_idle_oe", ram1_oe_n, 1);
        @(posedge clk); #1;
        req_en_n = 1'b1;
        wait_ack("held2");
        @(posedge clk); #1;
        chk("held_n_oe", n_oe, 4);

        // Asynchronous reset in the middle of WR2 aborts the write.
        req_write = 1'b1; addr = 16'hBF10; wdata = 16'h1234; req_en_n = 1'b0;
        @(posedge clk); #1;
        req_en_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_pre_we", ram1_we_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_strobes", {ram1_en_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn}, 5'h1f);
        chk("arst_dq_oe", bus_dq_oe, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ack", ack, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_sb_empty", sb.size(), 0);
        access("post_rst", 0, 16'h0042, 16'h0000, 16'hC0DE, 16'hC0DE, 3, 2, 2, 0, 0, 0);

        chk("invariants", n_inv, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
